// File: rtl/axi_mem_responder.sv
// AXI4 memory-mapped responder backed by a byte-lane word RAM.
// Independent read and write paths, one outstanding INCR burst each.
module axi_mem_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [7:0]                awlen,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [7:0]                arlen,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int OFFS       = $clog2(WORD_BYTES);
    localparam int IDX_BITS   = $clog2(MEM_DEPTH);
    localparam int IDX_W      = IDX_BITS + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Any address bit above the RAM range folds into the carry (out-of-range) bit.
    function automatic logic [IDX_W-1:0] start_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = addr >> OFFS;
        return {|word[ADDR_WIDTH-1:IDX_BITS], word[IDX_BITS-1:0]};
    endfunction

    // Carry is sticky so a long burst can never wrap back into the RAM.
    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] cur);
        logic [IDX_W-1:0] sum;
        sum = cur + IDX_W'(1);
        return {cur[IDX_W-1] | sum[IDX_W-1], sum[IDX_BITS-1:0]};
    endfunction

    // ---------------- write path ----------------
    logic [1:0]          w_state_reg;
    logic [ID_WIDTH-1:0] w_id_reg;
    logic [IDX_W-1:0]    w_idx_reg;
    logic [7:0]          w_len_reg;
    logic [7:0]          w_beat_reg;
    logic                w_err_reg;

    logic aw_hs, w_hs, b_hs, w_commit, w_final;

    assign awready  = (w_state_reg == W_IDLE);
    assign wready   = (w_state_reg == W_DATA);
    assign bvalid   = (w_state_reg == W_RESP);
    assign bid      = w_id_reg;
    assign bresp    = w_err_reg ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs    = awready && awvalid;
    assign w_hs     = wready && wvalid;
    assign b_hs     = bvalid && bready;
    assign w_commit = w_hs && !w_idx_reg[IDX_W-1];
    assign w_final  = (w_beat_reg == w_len_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
            w_id_reg    <= '0;
            w_idx_reg   <= '0;
            w_len_reg   <= '0;
            w_beat_reg  <= '0;
            w_err_reg   <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_state_reg <= W_DATA;
                        w_id_reg    <= awid;
                        w_idx_reg   <= start_index(awaddr);
                        w_len_reg   <= awlen;
                        w_beat_reg  <= '0;
                        w_err_reg   <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_idx_reg  <= next_index(w_idx_reg);
                        w_beat_reg <= w_beat_reg + 8'd1;
                        if (w_idx_reg[IDX_W-1] || (wlast && !w_final) || (w_final && !wlast))
                            w_err_reg <= 1'b1;
                        if (wlast || w_final)
                            w_state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        w_state_reg <= W_IDLE;
                        w_err_reg   <= 1'b0;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    logic [0:0]          r_state_reg;
    logic [ID_WIDTH-1:0] r_id_reg;
    logic [IDX_W-1:0]    r_idx_reg;
    logic [7:0]          r_len_reg;
    logic [7:0]          r_beat_reg;
    logic                r_valid_reg;
    logic                r_last_reg;
    logic [1:0]          r_resp_reg;

    logic             ar_hs, r_hs, rd_load, rd_oor;
    logic [IDX_W-1:0] rd_idx;

    assign arready = (r_state_reg == R_IDLE);
    assign rvalid  = r_valid_reg;
    assign rlast   = r_last_reg;
    assign rresp   = r_resp_reg;
    assign rid     = r_id_reg;

    assign ar_hs   = arready && arvalid;
    assign r_hs    = r_valid_reg && rready;
    assign rd_idx  = (r_state_reg == R_IDLE) ? start_index(araddr) : next_index(r_idx_reg);
    assign rd_oor  = rd_idx[IDX_W-1];
    assign rd_load = ar_hs || (r_hs && !r_last_reg && (r_state_reg == R_DATA));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= R_IDLE;
            r_id_reg    <= '0;
            r_idx_reg   <= '0;
            r_len_reg   <= '0;
            r_beat_reg  <= '0;
            r_valid_reg <= 1'b0;
            r_last_reg  <= 1'b0;
            r_resp_reg  <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_reg <= R_DATA;
                        r_id_reg    <= arid;
                        r_len_reg   <= arlen;
                        r_idx_reg   <= rd_idx;
                        r_beat_reg  <= '0;
                        r_valid_reg <= 1'b1;
                        r_last_reg  <= (arlen == 8'd0);
                        r_resp_reg  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (r_last_reg) begin
                            r_state_reg <= R_IDLE;
                            r_valid_reg <= 1'b0;
                            r_last_reg  <= 1'b0;
                        end else begin
                            r_idx_reg  <= rd_idx;
                            r_beat_reg <= r_beat_reg + 8'd1;
                            r_last_reg <= ((r_beat_reg + 8'd1) == r_len_reg);
                            r_resp_reg <= rd_oor ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // ---------------- byte-lane RAM ----------------
    // The registered read samples the array before the same-edge write lands,
    // so a read/write collision on one word returns the old contents.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (w_commit && wstrb[gi])
                    lane_mem[w_idx_reg[IDX_BITS-1:0]] <= wdata[gi*8 +: 8];
            end

            always_ff @(posedge clk) begin
                if (rst)
                    lane_rd_reg <= 8'h00;
                else if (rd_load)
                    lane_rd_reg <= rd_oor ? 8'h00 : lane_mem[rd_idx[IDX_BITS-1:0]];
            end

            assign rdata[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule
